hack_cpu: RTL

//   Instruction-executing core that drives the existing 16-bit Hack ALU (control bits zx,nx,zy,ny,f,no)
//   and consumes its zr/ng status flags to make jump decisions. Holds the A, D and PC registers,

---
 rtl/hack_pkg.sv | 72 +++++++
 rtl/alu.sv | 32 +++
 rtl/hack_pc.sv | 31 +++
 rtl/hack_cpu.sv | 89 ++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Hack CPU shared definitions: instruction field positions, dest/jump/comp encodings, jump helper.
// Pure declarations; no latency or backpressure of its own.
package hack_pkg;

   localparam int WIDTH  = 16;
   localparam int ADDR_W = 15;

   localparam int OP_BIT  = 15;
   localparam int A_BIT   = 12;
   localparam int COMP_HI = 11;
   localparam int COMP_LO = 6;
   localparam int DEST_HI = 5;
   localparam int DEST_LO = 3;
   localparam int JMP_HI  = 2;
   localparam int JMP_LO  = 0;

   typedef enum logic [2:0] {
      DEST_NULL = 3'b000,
      DEST_M    = 3'b001,
      DEST_D    = 3'b010,
      DEST_MD   = 3'b011,
      DEST_A    = 3'b100,
      DEST_AM   = 3'b101,
      DEST_AD   = 3'b110,
      DEST_AMD  = 3'b111
   } dest_e;

   typedef enum logic [2:0] {
      JMP_NULL = 3'b000,
      JMP_JGT  = 3'b001,
      JMP_JEQ  = 3'b010,
      JMP_JGE  = 3'b011,
      JMP_JLT  = 3'b100,
      JMP_JNE  = 3'b101,
      JMP_JLE  = 3'b110,
      JMP_JMP  = 3'b111
   } jump_e;

   localparam logic [5:0] COMP_ZERO    = 6'b101010;
   localparam logic [5:0] COMP_ONE     = 6'b111111;
   localparam logic [5:0] COMP_NEG1    = 6'b111010;
   localparam logic [5:0] COMP_D       = 6'b001100;
   localparam logic [5:0] COMP_A       = 6'b110000;
   localparam logic [5:0] COMP_NOTD    = 6'b001101;
   localparam logic [5:0] COMP_NOTA    = 6'b110001;
   localparam logic [5:0] COMP_NEGD    = 6'b001111;
   localparam logic [5:0] COMP_NEGA    = 6'b110011;
   localparam logic [5:0] COMP_DPLUS1  = 6'b011111;
   localparam logic [5:0] COMP_APLUS1  = 6'b110111;
   localparam logic [5:0] COMP_DMINUS1 = 6'b001110;
   localparam logic [5:0] COMP_AMINUS1 = 6'b110010;
   localparam logic [5:0] COMP_DPLUSA  = 6'b000010;
   localparam logic [5:0] COMP_DMINUSA = 6'b010011;
   localparam logic [5:0] COMP_AMINUSD = 6'b000111;
   localparam logic [5:0] COMP_DANDA   = 6'b000000;
   localparam logic [5:0] COMP_DORA    = 6'b010101;

   // Bit order matches the instruction word, so a plain cast decodes it.
   typedef struct packed {
      logic       op;
      logic [1:0] rsvd;
      logic       a;
      logic [5:0] comp;
      logic [2:0] dest;
      logic [2:0] jmp;
   } c_instr_t;

   function automatic logic jump_taken(input logic [2:0] jmp, input logic zr, input logic ng);
      return (jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr);
   endfunction

endpackage

// File: rtl/alu.sv
// Hack ALU: zero/negate each operand, add or AND, optionally negate result; reports zr/ng.
// Purely combinational, zero latency, no flow control.
module alu #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             zx,
   input  logic             nx,
   input  logic             zy,
   input  logic             ny,
   input  logic             f,
   input  logic             no,
   output logic [WIDTH-1:0] out,
   output logic             zr,
   output logic             ng
);

   logic [WIDTH-1:0] x1, x2, y1, y2, r;

   always_comb begin
      x1  = zx ? '0 : x;
      x2  = nx ? ~x1 : x1;
      y1  = zy ? '0 : y;
      y2  = ny ? ~y1 : y1;
      r   = f ? (x2 + y2) : (x2 & y2);
      out = no ? ~r : r;
      zr  = (out == '0);
      ng  = out[WIDTH-1];
   end

endmodule

// File: rtl/hack_pc.sv
// Program counter: reset to 0, hold on stall, load on jump, otherwise increment (wraps).
// Update visible one cycle after an enabled instruction; en=0 holds the count.
module hack_pc #(
   parameter int ADDR_W = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
   output logic [ADDR_W-1:0] pc
);

   logic [ADDR_W-1:0] pc_d, pc_q;

   always_comb begin
      pc_d = pc_q;
      if (en) begin
         if (load) pc_d = load_addr;
         else      pc_d = pc_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) pc_q <= '0;
      else     pc_q <= pc_d;
   end

   assign pc = pc_q;

endmodule

// File: rtl/hack_cpu.sv
// Hack CPU core: holds A/D/PC, decodes A/C instructions, drives the ALU and RAM write strobe.
// One instruction per cycle with instr_valid=1; instr_valid=0 stalls with no state change.
module hack_cpu
   import hack_pkg::*;
#(
   parameter int WIDTH  = hack_pkg::WIDTH,
   parameter int ADDR_W = hack_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   input  logic [WIDTH-1:0]  instruction,
   input  logic [WIDTH-1:0]  inM,
   output logic [WIDTH-1:0]  outM,
   output logic              writeM,
   output logic [ADDR_W-1:0] addressM,
   output logic [ADDR_W-1:0] pc
);

   logic [WIDTH-1:0] a_d, a_q;
   logic [WIDTH-1:0] d_d, d_q;
   logic [WIDTH-1:0] alu_y, alu_out;
   logic             alu_zr, alu_ng;
   logic             is_c;
   logic             take_jump;
   c_instr_t         ci;
   logic [1:0]       unused_rsvd;

   assign ci          = c_instr_t'(instruction);
   assign unused_rsvd = ci.rsvd;
   assign is_c        = instruction[OP_BIT];

   // The ALU sees the comp field on every cycle, so outM is valid even for A-instructions and stalls.
   assign alu_y = instruction[A_BIT] ? inM : a_q;

   alu #(.WIDTH(WIDTH)) u_alu (
      .x   (d_q),
      .y   (alu_y),
      .zx  (ci.comp[5]),
      .nx  (ci.comp[4]),
      .zy  (ci.comp[3]),
      .ny  (ci.comp[2]),
      .f   (ci.comp[1]),
      .no  (ci.comp[0]),
      .out (alu_out),
      .zr  (alu_zr),
      .ng  (alu_ng)
   );

   assign take_jump = instr_valid & is_c & jump_taken(ci.jmp, alu_zr, alu_ng);

   always_comb begin
      a_d = a_q;
      d_d = d_q;
      if (instr_valid) begin
         if (!is_c) begin
            a_d = instruction;
         end else begin
            if (ci.dest[2]) a_d = alu_out;
            if (ci.dest[1]) d_d = alu_out;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q <= '0;
         d_q <= '0;
      end else begin
         a_q <= a_d;
         d_q <= d_d;
      end
   end

   // Jump target is the pre-update A, even when the same instruction also writes A.
   hack_pc #(.ADDR_W(ADDR_W)) u_pc (
      .clk       (clk),
      .rst       (rst),
      .en        (instr_valid),
      .load      (take_jump),
      .load_addr (a_q[ADDR_W-1:0]),
      .pc        (pc)
   );

   assign outM     = alu_out;
   assign writeM   = instr_valid & ~rst & is_c & ci.dest[0];
   assign addressM = a_q[ADDR_W-1:0];

endmodule
